// File: rtl/vga_fb_arbiter_if.sv
// Requester-side bus of the framebuffer arbiter: display reader and pixel writer.
// The master modport is the requester side; the slave modport is the arbiter.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_ready, rd_rvalid, rd_rdata, wr_ready
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_ready, rd_rvalid, rd_rdata, wr_ready
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: reader priority in active video with a
// bounded writer wait, round-robin in blanking, registered SRAM port.
module vga_fb_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 12,
  parameter int MAX_WR_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_video,
  vga_fb_arbiter_if.slave   bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {LAST_RD = 1'b0, LAST_WR = 1'b1} rr_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WR_WAIT);

  rr_t        rr_last_reg;
  logic [7:0] wr_wait_reg;
  logic [1:0] rd_pipe_reg;

  logic conflict;
  logic wr_wins;
  logic rd_fire;
  logic wr_fire;

  // wr_wins only matters when both requesters are valid
  always_comb begin
    conflict = bus.rd_valid && bus.wr_valid;
    if (active_video) begin
      wr_wins = (wr_wait_reg == WAIT_MAX);
    end else begin
      wr_wins = (rr_last_reg == LAST_RD);
    end
    rd_fire = bus.rd_valid && !(conflict && wr_wins);
    wr_fire = bus.wr_valid && (!bus.rd_valid || wr_wins);
  end

  assign bus.rd_ready  = rd_fire;
  assign bus.wr_ready  = wr_fire;
  assign bus.rd_rvalid = rd_pipe_reg[1];
  assign bus.rd_rdata  = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_pipe_reg <= '0;
    end else begin
      mem_en      <= rd_fire || wr_fire;
      mem_we      <= wr_fire;
      rd_pipe_reg <= {rd_pipe_reg[0], rd_fire};
      if (wr_fire) begin
        mem_addr  <= bus.wr_addr;
        mem_wdata <= bus.wr_data;
      end else if (rd_fire) begin
        mem_addr  <= bus.rd_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_reg <= LAST_RD;
      wr_wait_reg <= '0;
    end else begin
      if (conflict) begin
        rr_last_reg <= wr_fire ? LAST_WR : LAST_RD;
      end
      if (wr_fire) begin
        wr_wait_reg <= '0;
      end else if (bus.wr_valid && (wr_wait_reg < WAIT_MAX)) begin
        wr_wait_reg <= wr_wait_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (stat_clr) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: grant vector table plus multi-cycle
// sequences for read latency, starvation escape, round-robin, reset and stats.
module tb_vga_fb_arbiter;
  localparam int AW = 17;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          active_video = 1'b0;
  logic          stat_clr = 1'b0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   conflict_cnt;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WR_WAIT(4)) dut (
    .clk(clk), .rst(rst), .active_video(active_video), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_clr(stat_clr), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency after mem_en && !mem_we
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Requester protocol monitor: valid must hold until ready
  logic rd_pend = 1'b0;
  logic wr_pend = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      if ((rd_pend && !bus.rd_valid) || (wr_pend && !bus.wr_valid)) begin
        total++;
        $display("FAIL protocol: valid dropped before ready rd=%b wr=%b, expected held", bus.rd_valid, bus.wr_valid);
      end
      rd_pend <= bus.rd_valid && !bus.rd_ready;
      wr_pend <= bus.wr_valid && !bus.wr_ready;
    end
  end

  typedef struct {
    logic rdv;
    logic wrv;
    logic av;
    logic exp_rd;
    logic exp_wr;
  } vec_t;

  vec_t vecs [14];

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.rd_valid = 1'b0;
    bus.wr_valid = 1'b0;
    stat_clr     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seen;
    // Hand-computed from reset with MAX_WR_WAIT=4 (wait/rr state noted per row)
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // read only
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // write only
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // blank, rr=R -> W
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // blank, rr=W -> R, wait=1
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // active, wait 1->2
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // wait 2->3
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // wait 3->4
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // wait==4 -> forced W
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // blank, rr=W -> R
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // write only
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // blank, rr=R -> W
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // active, wait 0 -> R
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // write only

    bus.rd_valid = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;

    // Reset state with both requesters asserting in active video
    rst = 1'b1;
    active_video = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rd_addr  = 17'h00042;
    bus.wr_addr  = 17'h00043;
    bus.wr_data  = 12'h555;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_en", mem_en, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst rd_rvalid", bus.rd_rvalid, 0);
    check("rst conflict_cnt", conflict_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst rd_ready", bus.rd_ready, 1);
    check("post-rst wr_ready", bus.wr_ready, 0);

    // Grant vector table
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.rd_valid = vecs[i].rdv;
      bus.wr_valid = vecs[i].wrv;
      active_video = vecs[i].av;
      bus.rd_addr  = AW'(i);
      bus.wr_addr  = AW'(i + 100);
      bus.wr_data  = DW'(i);
      #1;
      $display("vec %0d rd_valid=%b wr_valid=%b av=%b -> rd_ready=%b wr_ready=%b",
               i, vecs[i].rdv, vecs[i].wrv, vecs[i].av, bus.rd_ready, bus.wr_ready);
      check($sformatf("vec%0d rd_ready", i), bus.rd_ready, vecs[i].exp_rd);
      check($sformatf("vec%0d wr_ready", i), bus.wr_ready, vecs[i].exp_wr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d mem_en", i), mem_en, vecs[i].exp_rd | vecs[i].exp_wr);
      check($sformatf("vec%0d mem_we", i), mem_we, vecs[i].exp_wr);
    end

    // Write 0xABC to 0x00123, then read it back with fixed latency
    apply_reset();
    active_video = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 17'h00123;
    bus.wr_data  = 12'hABC;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    check("wr mem_we", mem_we, 1);
    check("wr mem_addr", mem_addr, 17'h00123);
    check("wr mem_wdata", mem_wdata, 12'hABC);
    $display("write addr=0x%05h data=0x%03h", 17'h00123, 12'hABC);
    @(negedge clk);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 17'h00123;
    #1;
    check("rd rd_ready", bus.rd_ready, 1);
    @(posedge clk);
    #1;
    bus.rd_valid = 1'b0;
    check("rd t+1 mem_en", mem_en, 1);
    check("rd t+1 mem_we", mem_we, 0);
    check("rd t+1 mem_addr", mem_addr, 17'h00123);
    check("rd t+1 rd_rvalid", bus.rd_rvalid, 0);
    @(posedge clk);
    #1;
    check("rd t+2 rd_rvalid", bus.rd_rvalid, 1);
    check("rd t+2 rd_rdata", bus.rd_rdata, 12'hABC);
    $display("read addr=0x%05h data=0x%03h", 17'h00123, bus.rd_rdata);
    @(posedge clk);
    #1;
    check("rd t+3 rd_rvalid", bus.rd_rvalid, 0);

    // Active-video conflict: R,R,R,R,W repeating, counter tracks cycles
    apply_reset();
    active_video = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      $display("active cycle %0d rd_ready=%b wr_ready=%b", i, bus.rd_ready, bus.wr_ready);
      check($sformatf("active%0d wr_ready", i), bus.wr_ready, (i % 5) == 4);
      check($sformatf("active%0d rd_ready", i), bus.rd_ready, (i % 5) != 4);
      @(negedge clk);
    end
    check("active conflict_cnt", conflict_cnt, 10);

    // Blanking conflict from reset: W,R,W,R
    apply_reset();
    active_video = 1'b0;
    bus.rd_valid = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rd_addr  = 17'h00077;
    bus.wr_addr  = 17'h00055;
    bus.wr_data  = 12'hF00;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("blank%0d wr_ready", i), bus.wr_ready, (i % 2) == 0);
      @(posedge clk);
      #1;
      $display("blank cycle %0d mem_we=%b mem_addr=0x%05h mem_wdata=0x%03h", i, mem_we, mem_addr, mem_wdata);
      check($sformatf("blank%0d mem_we", i), mem_we, (i % 2) == 0);
      check($sformatf("blank%0d mem_addr", i), mem_addr, ((i % 2) == 0) ? 17'h00055 : 17'h00077);
      if ((i % 2) == 0) check($sformatf("blank%0d mem_wdata", i), mem_wdata, 12'hF00);
      @(negedge clk);
    end

    // Reset pulse in the cycle after a read handshake drops the read
    apply_reset();
    active_video = 1'b1;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 17'h00123;
    @(posedge clk);
    #1;
    bus.rd_valid = 1'b0;
    check("rstpulse mem_en before", mem_en, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rstpulse mem_en async", mem_en, 0);
    @(posedge clk);
    #1;
    check("rstpulse mem_en during", mem_en, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.rd_rvalid || mem_en) seen++;
    end
    check("rstpulse no rvalid/mem_en", seen, 0);

    // Conflict counter saturation and clear-over-increment
    apply_reset();
    active_video = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("sat conflict_cnt", conflict_cnt, 16'hFFFF);
    @(negedge clk);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clr conflict_cnt", conflict_cnt, 0);
    @(posedge clk);
    #1;
    check("clr+1 conflict_cnt", conflict_cnt, 1);
    $display("stats conflict_cnt=%0d after clear", conflict_cnt);

    apply_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbiter for the single-port framebuffer SRAM behind the VGA output path. It shares the SRAM between two requesters: the display line-prefetch reader and a pixel writer (drawing engine or host). Priority depends on the timing generator's active-video flag: the reader wins during active video, with a bounded-starvation escape for the writer, and the two round-robin during blanking. The block also drives the SRAM port and returns read data with fixed latency.

## Interface
- ADDR_W, 17, framebuffer word address width
- DATA_W, 12, pixel width (RGB 4:4:4)
- MAX_WR_WAIT, 16, writer wait cycles during active video before it is forced one grant; legal range 1..255
- clk  in  1  single clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- active_video  in  1  registered pixel-enable from the timing generator
- rd_valid  in  1  reader request; held with rd_addr until rd_ready
- rd_addr  in  ADDR_W  read address
- rd_ready  out  1  read grant; handshake when rd_valid && rd_ready
- rd_rvalid  out  1  read data valid
- rd_rdata  out  DATA_W  read data
- wr_valid  in  1  writer request; held with wr_addr/wr_data until wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write grant
- mem_en, mem_we  out  1 each  SRAM enable / write enable, registered
- mem_addr  out  ADDR_W  registered SRAM address
- mem_wdata  out  DATA_W  registered SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_en && !mem_we
- stat_clr  in  1  synchronous clear of conflict_cnt
- conflict_cnt  out  16  saturating count of cycles with rd_valid && wr_valid

## Operation
- Grant logic is combinational. At most one of rd_ready and wr_ready is high, and a ready is never raised without its own valid.
- Exactly one valid request: that requester is granted.
- Both valid, active_video=1: reader granted, unless wr_wait == MAX_WR_WAIT, in which case the writer is granted.
- Both valid, active_video=0: round-robin on the rr_last register (the requester last granted under conflict). The other requester wins and rr_last is updated. rr_last resets to "reader", so the first blanking conflict goes to the writer.
- wr_wait is an 8-bit counter. It increments (saturating at MAX_WR_WAIT) each cycle with wr_valid && !wr_ready, clears on write handshake, and holds when wr_valid=0. It resets to 0.
- On a handshake the SRAM stage registers: mem_en=1, mem_we=1 for a write or 0 for a read, mem_addr/mem_wdata from the winner. With no handshake, mem_en=0, mem_we=0, and addr/wdata hold.
- Reads: a 2-stage valid pipe. rd_rvalid=1 exactly 2 cycles after the read handshake. rd_rdata = mem_rdata passed through combinationally and only meaningful while rd_rvalid=1.
- Back-to-back reads or writes can be granted every cycle. Throughput is 1 access/cycle.
- conflict_cnt increments on every cycle with both valids, saturating at 0xFFFF. stat_clr clears it in the same edge and has priority over increment.

## Timing
- Reset values: rd_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, conflict_cnt=0, wr_wait=0, rr_last=reader, read pipe empty. rd_ready and wr_ready follow the valids immediately after reset release.
- Read handshake at edge t: mem_en=1 and mem_we=0 from t+1, then rd_rvalid=1 from t+2.
- Write handshake at edge t: mem_en=1, mem_we=1 and data from t+1. There is no response.
- An active_video change takes effect on grant in the same cycle. There is no arbitration hysteresis.
- Reset asserted mid-operation: in-flight reads are dropped, no rd_rvalid is produced, and the SRAM stage goes idle immediately (asynchronous).
- A requester dropping valid before ready is a protocol violation. The bench flags it; the RTL need not handle it.

## Test plan
- Reset with both valids=1 and active_video=1: all registered outputs are 0 during reset. After release, rd_ready=1 and wr_ready=0.
- Read only: handshake at addr 0x00123, SRAM model returns 0xABC. Expect mem_en=1, mem_we=0, mem_addr=0x00123 one cycle later, and rd_rvalid=1 with rd_rdata=0xABC two cycles after handshake.
- Active-video conflict with MAX_WR_WAIT=4 and both valid continuously: grant pattern R,R,R,R,W repeating. conflict_cnt equals the cycle count.
- Blanking conflict from reset with both valid: grants W,R,W,R. Each write appears on mem with mem_we=1 and the correct wr_data, e.g. 0xF00.
- Reset pulse one cycle after a read handshake: no rd_rvalid ever appears for that read, and mem_en=0 during and after reset.
- conflict_cnt preloaded to saturation with 65540 conflict cycles reads 0xFFFF. A stat_clr cycle that is also a conflict cycle yields 0, then 1 on the next conflict cycle.
